// File: rtl/pmod_freq_meter_if.sv
// Bundle between a frequency-meter core and its user: measured pin and enable in, result and status out.
// master drives the pin and enable; slave is the meter itself.
interface pmod_freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             sig_in;
    logic             meas_en;
    logic [CNT_W-1:0] freq_count;
    logic             freq_valid;
    logic             in_range;
    logic             no_signal;
    logic             cnt_sat;
    logic             busy;

    modport master (
        output sig_in, meas_en,
        input  freq_count, freq_valid, in_range, no_signal, cnt_sat, busy
    );

    modport slave (
        input  sig_in, meas_en,
        output freq_count, freq_valid, in_range, no_signal, cnt_sat, busy
    );
endinterface

// File: rtl/pmod_freq_meter.sv
// Gated rising-edge counter for an async pin: one result every GATE_CYCLES+2 clocks while meas_en is high.
// Pin-to-edge latency 2-3 clocks; no backpressure, freq_valid is a one-cycle pulse the consumer must catch.
module pmod_freq_meter #(
    parameter int GATE_CYCLES = 100000,
    parameter int CNT_W       = 32,
    parameter int EXP_MIN     = 2147,
    parameter int EXP_MAX     = 2149
) (
    input  logic              clk_ext,
    input  logic              rst_ext_n,
    pmod_freq_meter_if.slave  bus
);
    localparam int               GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  LIM_MIN   = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0]  LIM_MAX   = CNT_W'(EXP_MAX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_MEASURE,
        ST_REPORT
    } state_t;

    state_t            state_q, state_d;
    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [GATE_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [CNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic              sat_q, sat_d;
    logic [CNT_W-1:0]  freq_count_q, freq_count_d;
    logic              in_range_q, in_range_d;
    logic              no_signal_q, no_signal_d;
    logic              cnt_sat_q, cnt_sat_d;

    logic              edge_pls;
    logic [CNT_W-1:0]  edge_nxt;
    logic              sat_nxt;

    always_comb begin
        state_d      = state_q;
        s1_d         = bus.sig_in;
        s2_d         = s1_q;
        s3_d         = s2_q;
        gate_cnt_d   = gate_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        sat_d        = sat_q;
        freq_count_d = freq_count_q;
        in_range_d   = in_range_q;
        no_signal_d  = no_signal_q;
        cnt_sat_d    = cnt_sat_q;

        edge_pls = s2_q & ~s3_q;
        // Saturating count: once at all-ones further edges only raise the sticky flag.
        edge_nxt = edge_cnt_q;
        sat_nxt  = sat_q;
        if (edge_pls) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt_q + CNT_W'(1);
            end
        end

        unique case (state_q)
            ST_IDLE: begin
                if (bus.meas_en) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                gate_cnt_d = '0;
                edge_cnt_d = '0;
                sat_d      = 1'b0;
                state_d    = bus.meas_en ? ST_MEASURE : ST_IDLE;
            end
            ST_MEASURE: begin
                if (!bus.meas_en) begin
                    state_d = ST_IDLE;
                end else begin
                    gate_cnt_d = gate_cnt_q + GATE_W'(1);
                    edge_cnt_d = edge_nxt;
                    sat_d      = sat_nxt;
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d      = ST_REPORT;
                        freq_count_d = edge_nxt;
                        no_signal_d  = (edge_nxt == '0);
                        cnt_sat_d    = sat_nxt;
                        in_range_d   = (edge_nxt >= LIM_MIN) && (edge_nxt <= LIM_MAX);
                    end
                end
            end
            ST_REPORT: begin
                state_d = bus.meas_en ? ST_ARM : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_ext) begin
        if (!rst_ext_n) begin
            state_q      <= ST_IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            gate_cnt_q   <= '0;
            edge_cnt_q   <= '0;
            sat_q        <= 1'b0;
            freq_count_q <= '0;
            in_range_q   <= 1'b0;
            no_signal_q  <= 1'b1;
            cnt_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= s1_d;
            s2_q         <= s2_d;
            s3_q         <= s3_d;
            gate_cnt_q   <= gate_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            sat_q        <= sat_d;
            freq_count_q <= freq_count_d;
            in_range_q   <= in_range_d;
            no_signal_q  <= no_signal_d;
            cnt_sat_q    <= cnt_sat_d;
        end
    end

    assign bus.freq_count = freq_count_q;
    assign bus.freq_valid = (state_q == ST_REPORT);
    assign bus.in_range   = in_range_q;
    assign bus.no_signal  = no_signal_q;
    assign bus.cnt_sat    = cnt_sat_q;
    assign bus.busy       = (state_q == ST_ARM) || (state_q == ST_MEASURE);
endmodule
